maze_world_seq: RTL and testbench

- Registered, run-time reloadable successor to the combinational maze world.
- Holds a double-buffered maze: rows are streamed into a shadow buffer, and a commit swaps it into the active maze.
- Recomputes the four per-cell direction constraint arrays in one registered settle cycle.
- Owns the player position: accepts move requests, applies the constraints and reports accepted or blocked moves to the game FSM.

---
 rtl/maze_world_seq.sv | 181 ++++++++++++++++++
 tb/tb_maze_world_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_world_seq.sv
// maze_world_seq: registered, reloadable maze world.
// Rows stream into a shadow buffer; commit swaps it into the active maze.
// Per-cell direction constraints are rebuilt in one registered settle cycle,
// and the player position is updated by move requests against them.
module maze_world_seq #(
   parameter int size_y  = 20,
   parameter int size_x  = 40,
   parameter int start_y = 0,
   parameter int start_x = 0,
   localparam int YW = $clog2(size_y),
   localparam int XW = $clog2(size_x)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_valid,
   input  logic [YW-1:0]                 load_row,
   input  logic [0:size_x-1]             load_data,
   output logic                          load_err,
   input  logic                          commit,
   input  logic                          move_valid,
   input  logic [1:0]                    move_dir,
   output logic                          move_ready,
   output logic                          move_done,
   output logic                          move_blocked,
   output logic [YW-1:0]                 player_y,
   output logic [XW-1:0]                 player_x,
   output logic [size_y-1:0][0:size_x-1] maze,
   output logic [size_y-1:0][0:size_x-1] up_constraint,
   output logic [size_y-1:0][0:size_x-1] down_constraint,
   output logic [size_y-1:0][0:size_x-1] left_constraint,
   output logic [size_y-1:0][0:size_x-1] right_constraint,
   output logic                          constraint_valid
);

   typedef enum logic {SETTLE, RUN} state_t;

   typedef logic [size_y-1:0][0:size_x-1] grid_t;

   state_t          state_q, state_d;
   grid_t           shadow_q, shadow_d;
   grid_t           maze_q, maze_d;
   grid_t           up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
   grid_t           up_n, down_n, left_n, right_n;
   logic            cvalid_q, cvalid_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic            blocked_q, blocked_d;
   logic            err_q, err_d;
   logic [YW-1:0]   py_q, py_d;
   logic [XW-1:0]   px_q, px_d;

   // Constraint arrays derived from the active maze; borders count as walls.
   always_comb begin
      // Row y of up takes maze row y-1 (row 0 fully blocked); down mirrors it.
      up_n   = {maze_q[size_y-2:0], {size_x{1'b1}}};
      down_n = {{size_x{1'b1}}, maze_q[size_y-1:1]};
      left_n  = '0;
      right_n = '0;
      for (int unsigned y = 0; y < size_y; y++) begin
         left_n[y]  = {1'b1, maze_q[y][0:size_x-2]};
         right_n[y] = {maze_q[y][1:size_x-1], 1'b1};
      end
   end

   // Next-state logic: shadow loads, settle/run sequencing, commit and moves.
   always_comb begin
      logic blk;
      blk       = 1'b0;
      state_d   = state_q;
      shadow_d  = shadow_q;
      maze_d    = maze_q;
      up_d      = up_q;
      down_d    = down_q;
      left_d    = left_q;
      right_d   = right_q;
      cvalid_d  = cvalid_q;
      py_d      = py_q;
      px_d      = px_q;
      done_d    = 1'b0;
      blocked_d = 1'b0;
      err_d     = 1'b0;

      // Loads land before a same-edge commit copies the shadow.
      if (load_valid) begin
         if (int'(load_row) >= size_y) begin
            err_d = 1'b1;
         end else begin
            shadow_d[load_row] = load_data;
         end
      end

      case (state_q)
         SETTLE: begin
            up_d     = up_n;
            down_d   = down_n;
            left_d   = left_n;
            right_d  = right_n;
            cvalid_d = 1'b1;
            state_d  = RUN;
         end
         default: ;
      endcase

      if (commit) begin
         maze_d   = shadow_d;
         py_d     = YW'(start_y);
         px_d     = XW'(start_x);
         cvalid_d = 1'b0;
         state_d  = SETTLE;
      end else if (move_valid && ready_q) begin
         case (move_dir)
            2'd0:    blk = up_q[py_q][px_q];
            2'd1:    blk = down_q[py_q][px_q];
            2'd2:    blk = left_q[py_q][px_q];
            default: blk = right_q[py_q][px_q];
         endcase
         done_d    = 1'b1;
         blocked_d = blk;
         if (!blk) begin
            case (move_dir)
               2'd0:    py_d = py_q - YW'(1);
               2'd1:    py_d = py_q + YW'(1);
               2'd2:    px_d = px_q - XW'(1);
               default: px_d = px_q + XW'(1);
            endcase
         end
      end

      // Ready tracks the state being entered so it rises with constraint_valid.
      ready_d = (state_d == RUN);
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SETTLE;
         shadow_q  <= '0;
         maze_q    <= '0;
         up_q      <= '0;
         down_q    <= '0;
         left_q    <= '0;
         right_q   <= '0;
         cvalid_q  <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         blocked_q <= 1'b0;
         err_q     <= 1'b0;
         py_q      <= YW'(start_y);
         px_q      <= XW'(start_x);
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         maze_q    <= maze_d;
         up_q      <= up_d;
         down_q    <= down_d;
         left_q    <= left_d;
         right_q   <= right_d;
         cvalid_q  <= cvalid_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         blocked_q <= blocked_d;
         err_q     <= err_d;
         py_q      <= py_d;
         px_q      <= px_d;
      end
   end

   assign load_err         = err_q;
   assign move_ready       = ready_q;
   assign move_done        = done_q;
   assign move_blocked     = blocked_q;
   assign player_y         = py_q;
   assign player_x         = px_q;
   assign maze             = maze_q;
   assign up_constraint    = up_q;
   assign down_constraint  = down_q;
   assign left_constraint  = left_q;
   assign right_constraint = right_q;
   assign constraint_valid = cvalid_q;

endmodule

// File: tb/tb_maze_world_seq.sv
// Testbench for maze_world_seq: directed scenarios then random traffic,
// every cycle compared against a cell-level reference model of the maze world.
module tb_maze_world_seq;

   localparam int SY   = 6;
   localparam int SX   = 8;
   localparam int ST_Y = 0;
   localparam int ST_X = 0;
   localparam int YW   = $clog2(SY);
   localparam int XW   = $clog2(SX);

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  load_valid = 1'b0;
   logic [YW-1:0]         load_row = '0;
   logic [0:SX-1]         load_data = '0;
   logic                  load_err;
   logic                  commit = 1'b0;
   logic                  move_valid = 1'b0;
   logic [1:0]            move_dir = '0;
   logic                  move_ready, move_done, move_blocked;
   logic [YW-1:0]         player_y;
   logic [XW-1:0]         player_x;
   logic [SY-1:0][0:SX-1] maze, up_c, down_c, left_c, right_c;
   logic                  constraint_valid;

   maze_world_seq #(
      .size_y (SY),
      .size_x (SX),
      .start_y(ST_Y),
      .start_x(ST_X)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .load_valid      (load_valid),
      .load_row        (load_row),
      .load_data       (load_data),
      .load_err        (load_err),
      .commit          (commit),
      .move_valid      (move_valid),
      .move_dir        (move_dir),
      .move_ready      (move_ready),
      .move_done       (move_done),
      .move_blocked    (move_blocked),
      .player_y        (player_y),
      .player_x        (player_x),
      .maze            (maze),
      .up_constraint   (up_c),
      .down_constraint (down_c),
      .left_constraint (left_c),
      .right_constraint(right_c),
      .constraint_valid(constraint_valid)
   );

   always #5 clk = ~clk;

   // Reference model state.
   bit m_shadow[SY][SX];
   bit m_maze[SY][SX];
   int m_py, m_px;
   bit m_settling, m_cvalid, m_done, m_blocked, m_err;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outside the grid counts as a wall.
   function automatic bit m_wall(input int y, input int x);
      if (y < 0 || y >= SY || x < 0 || x >= SX) return 1'b1;
      return m_maze[y][x];
   endfunction

   task automatic m_reset();
      for (int y = 0; y < SY; y++)
         for (int x = 0; x < SX; x++) begin
            m_shadow[y][x] = 1'b0;
            m_maze[y][x]   = 1'b0;
         end
      m_py = ST_Y; m_px = ST_X;
      m_settling = 1'b1; m_cvalid = 1'b0;
      m_done = 1'b0; m_blocked = 1'b0; m_err = 1'b0;
   endtask

   task automatic m_step(input bit lv, input int lr, input logic [0:SX-1] ld,
                         input bit cm, input bit mv, input int md);
      int ny, nx;
      m_err = 1'b0; m_done = 1'b0; m_blocked = 1'b0;
      if (lv) begin
         if (lr >= SY) m_err = 1'b1;
         else for (int x = 0; x < SX; x++) m_shadow[lr][x] = ld[x];
      end
      if (cm) begin
         m_maze = m_shadow;
         m_py = ST_Y; m_px = ST_X;
         m_cvalid = 1'b0; m_settling = 1'b1;
      end else if (m_settling) begin
         m_settling = 1'b0; m_cvalid = 1'b1;
      end else if (mv) begin
         ny = m_py; nx = m_px;
         case (md)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
         endcase
         m_done = 1'b1;
         m_blocked = m_wall(ny, nx);
         if (!m_blocked) begin m_py = ny; m_px = nx; end
      end
   endtask

   task automatic check_all();
      logic [SY-1:0][0:SX-1] em, eu, ed, el, er;
      for (int y = 0; y < SY; y++)
         for (int x = 0; x < SX; x++) begin
            em[y][x] = m_maze[y][x];
            eu[y][x] = m_wall(y - 1, x);
            ed[y][x] = m_wall(y + 1, x);
            el[y][x] = m_wall(y, x - 1);
            er[y][x] = m_wall(y, x + 1);
         end
      chk("load_err", 64'(load_err), 64'(m_err));
      chk("move_done", 64'(move_done), 64'(m_done));
      chk("move_blocked", 64'(move_blocked), 64'(m_blocked));
      chk("move_ready", 64'(move_ready), 64'(!m_settling));
      chk("constraint_valid", 64'(constraint_valid), 64'(m_cvalid));
      chk("player_y", 64'(player_y), 64'(m_py));
      chk("player_x", 64'(player_x), 64'(m_px));
      chk("maze", 64'(maze), 64'(em));
      if (m_cvalid) begin
         chk("up", 64'(up_c), 64'(eu));
         chk("down", 64'(down_c), 64'(ed));
         chk("left", 64'(left_c), 64'(el));
         chk("right", 64'(right_c), 64'(er));
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_maze", 64'(maze), 64'(0));
      chk("rst_up", 64'(up_c), 64'(0));
      chk("rst_down", 64'(down_c), 64'(0));
      chk("rst_left", 64'(left_c), 64'(0));
      chk("rst_right", 64'(right_c), 64'(0));
   endtask

   task automatic cyc(input bit lv, input int lr, input logic [0:SX-1] ld,
                      input bit cm, input bit mv, input int md);
      load_valid = lv; load_row = YW'(lr); load_data = ld;
      commit = cm; move_valid = mv; move_dir = 2'(md);
      m_step(lv, lr, ld, cm, mv, md);
      @(posedge clk); #1;
      load_valid = 1'b0; commit = 1'b0; move_valid = 1'b0;
      check_all();
   endtask

   task automatic idle();
      cyc(1'b0, 0, '0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      logic [0:SX-1] rd;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check_reset_outputs();
      rst_n = 1'b1;
      check_all();

      // Empty maze settles: border-only constraints.
      idle();
      idle();

      // Wall at (1,1), then commit and settle.
      cyc(1'b1, 1, 8'b0100_0000, 1'b0, 1'b0, 0);
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 0);
      idle();

      // Right accepted, down blocked by the wall, done pulse clears.
      cyc(1'b0, 0, '0, 1'b0, 1'b1, 3);
      cyc(1'b0, 0, '0, 1'b0, 1'b1, 1);
      idle();

      // Back to start; up and left blocked by the border.
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 0);
      idle();
      cyc(1'b0, 0, '0, 1'b0, 1'b1, 0);
      cyc(1'b0, 0, '0, 1'b0, 1'b1, 2);

      // Same-edge commit + move, and load + commit.
      cyc(1'b0, 0, '0, 1'b0, 1'b1, 3);
      cyc(1'b1, 3, 8'b0001_1000, 1'b0, 1'b0, 0);
      cyc(1'b0, 0, '0, 1'b1, 1'b1, 3);
      idle();
      cyc(1'b1, 2, 8'b1010_0101, 1'b1, 1'b0, 0);
      idle();

      // Out-of-range rows are rejected and leave the shadow untouched.
      cyc(1'b1, 6, 8'hFF, 1'b0, 1'b0, 0);
      cyc(1'b1, 7, 8'hFF, 1'b0, 1'b0, 0);
      idle();
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 0);
      idle();

      // Asynchronous reset in the middle of SETTLE.
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 0);
      rst_n = 1'b0;
      #2;
      m_reset();
      check_all();
      check_reset_outputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      cyc(1'b0, 0, '0, 1'b1, 1'b0, 0);
      idle();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rd = SX'($urandom) & SX'($urandom);
         cyc(($urandom_range(0, 99) < 30), int'($urandom_range(0, 7)), rd,
             ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60),
             int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
